mipi_phy_ser: RTL

MIPI_PHY_SER -- requirements
Module: mipi_phy_ser

---
 rtl/mipi_pkg.sv | 27 ++
 rtl/mipi_oserdes.sv | 42 ++++
 rtl/mipi_phy_ser.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mipi_pkg.sv
// Shared types and constants for the MIPI D-PHY HS lane serializer front end.
package mipi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLpx,
        StPrep,
        StHsZero,
        StSync,
        StData,
        StTrail,
        StExit
    } state_e;

    localparam logic [7:0] SYNC_WORD = 8'hB8;

    // {lp_p, lp_n}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    // Trail holds the complement of the final bit of the last word on the line.
    function automatic logic [7:0] trail_word(input logic [7:0] last_word);
        return {8{~last_word[7]}};
    endfunction

endpackage

// File: rtl/mipi_oserdes.sv
// Portable stand-in for the vendor 8:1 output serializer and differential buffer.
// Runs on a bit clock at 8x the byte clock, phase aligned; bit 0 leaves first.
module mipi_oserdes (
    input  logic       clk_ser_i,
    input  logic       rst_ni,
    input  logic [7:0] word_i,
    input  logic       oe_i,
    output logic       hs_dp_o,
    output logic       hs_dn_o
);

    logic [2:0] slot_q, slot_d;
    logic [7:0] shift_q, shift_d;
    logic       oe_q, oe_d;

    always_comb begin
        slot_d  = slot_q + 3'd1;
        shift_d = {1'b0, shift_q[7:1]};
        oe_d    = oe_q;
        if (slot_q == 3'd0) begin
            shift_d = word_i;
            oe_d    = oe_i;
        end
    end

    always_ff @(posedge clk_ser_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q  <= 3'd0;
            shift_q <= 8'h00;
            oe_q    <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            shift_q <= shift_d;
            oe_q    <= oe_d;
        end
    end

    // Both legs low models the tri-stated HS driver.
    assign hs_dp_o = oe_q & shift_q[0];
    assign hs_dn_o = oe_q & ~shift_q[0];

endmodule

// File: rtl/mipi_phy_ser.sv
// D-PHY data lane sequencer: LP entry, HS zero/sync, payload, trail and exit.
// Line outputs are registered from the current state, so they trail it by one cycle.
module mipi_phy_ser
    import mipi_pkg::*;
#(
    parameter int unsigned T_LPX       = 2,
    parameter int unsigned T_HS_ZERO   = 6,
    parameter int unsigned T_HS_TRAIL  = 4,
    parameter int unsigned T_HS_EXIT   = 4,
    parameter bit          USE_OSERDES = 1'b1
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       clk_ser,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       valid,
    input  logic       last,
    output logic       ready,
    input  logic       md_polarity,
    output logic [7:0] q,
    output logic       hs_oe,
    output logic       lp_p,
    output logic       lp_n,
    output logic       busy,
    output logic       underflow,
    output logic       hs_dp,
    output logic       hs_dn
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] LpxLoad   = CW'(T_LPX - 1);
    localparam logic [CW-1:0] ZeroLoad  = CW'(T_HS_ZERO - 1);
    localparam logic [CW-1:0] TrailLoad = CW'(T_HS_TRAIL - 1);
    localparam logic [CW-1:0] ExitLoad  = CW'(T_HS_EXIT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    lp_q, lp_d;
    logic          hs_oe_q, hs_oe_d;
    logic [7:0]    q_q, q_d;
    logic [7:0]    last_word_q, last_word_d;
    logic          underflow_q, underflow_d;
    logic          exit_q, exit_d;
    logic          armed_q, armed_d;
    logic [7:0]    word;
    logic          cnt_done;

    assign cnt_done = (cnt_q == '0);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_done ? cnt_q : cnt_q - 1'b1;
        unique case (state_q)
            StIdle: begin
                if (start && armed_q) begin
                    state_d = StLpx;
                    cnt_d   = LpxLoad;
                end
            end
            StLpx: begin
                if (cnt_done) begin
                    state_d = StPrep;
                    cnt_d   = LpxLoad;
                end
            end
            StPrep: begin
                if (cnt_done) begin
                    state_d = StHsZero;
                    cnt_d   = ZeroLoad;
                end
            end
            StHsZero: begin
                if (cnt_done) state_d = StSync;
            end
            StSync: state_d = StData;
            StData: begin
                // A stall cycle already emits the first trail word.
                if (!valid) begin
                    if (T_HS_TRAIL == 1) begin
                        state_d = StExit;
                        cnt_d   = ExitLoad;
                    end else begin
                        state_d = StTrail;
                        cnt_d   = TrailLoad - 1'b1;
                    end
                end else if (last) begin
                    state_d = StTrail;
                    cnt_d   = TrailLoad;
                end
            end
            StTrail: begin
                if (cnt_done) begin
                    state_d = StExit;
                    cnt_d   = ExitLoad;
                end
            end
            StExit: begin
                if (cnt_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        lp_d        = LP00;
        hs_oe_d     = 1'b0;
        word        = 8'h00;
        last_word_d = last_word_q;
        unique case (state_q)
            StIdle, StExit: lp_d = LP11;
            StLpx:          lp_d = LP01;
            StPrep:         hs_oe_d = cnt_done;
            StHsZero:       hs_oe_d = 1'b1;
            StSync: begin
                hs_oe_d     = 1'b1;
                word        = SYNC_WORD;
                last_word_d = SYNC_WORD;
            end
            StData: begin
                hs_oe_d = 1'b1;
                if (valid) begin
                    word        = data;
                    last_word_d = data;
                end else begin
                    word = trail_word(last_word_q);
                end
            end
            StTrail: begin
                hs_oe_d = 1'b1;
                word    = trail_word(last_word_q);
            end
            default: lp_d = LP11;
        endcase
        q_d         = word ^ {8{md_polarity}};
        underflow_d = (state_q == StData) && !valid;
        exit_d      = (state_q == StExit);
        armed_d     = 1'b1;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            lp_q        <= LP11;
            hs_oe_q     <= 1'b0;
            q_q         <= 8'h00;
            last_word_q <= 8'h00;
            underflow_q <= 1'b0;
            exit_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            lp_q        <= lp_d;
            hs_oe_q     <= hs_oe_d;
            q_q         <= q_d;
            last_word_q <= last_word_d;
            underflow_q <= underflow_d;
            exit_q      <= exit_d;
            armed_q     <= armed_d;
        end
    end

    assign lp_p      = lp_q[1];
    assign lp_n      = lp_q[0];
    assign hs_oe     = hs_oe_q;
    assign q         = q_q;
    assign underflow = underflow_q;
    assign ready     = (state_q == StData);
    // Busy also covers the last registered EXIT cycle still visible on the pins.
    assign busy      = (state_q != StIdle) || exit_q;

    if (USE_OSERDES) begin : g_oserdes
        mipi_oserdes u_oserdes (
            .clk_ser_i (clk_ser),
            .rst_ni    (resetb),
            .word_i    (q_q),
            .oe_i      (hs_oe_q),
            .hs_dp_o   (hs_dp),
            .hs_dn_o   (hs_dn)
        );
    end else begin : g_no_oserdes
        assign hs_dp = 1'b0;
        assign hs_dn = 1'b0;
    end

endmodule
